seq_detector_param: RTL and testbench

Parametrised serial pattern detector with a Moore-type output. It is the general form of the fixed two-flip-flop detectors in the finite-state-machine exercise set, and sits directly on a one-bit serial input sampled on the system clock. The pattern, its length and overlap mode are elaboration-time parameters. The block adds a clock enable, a synchronous clear, and a saturating match counter.

---
 rtl/seq_detector_param.sv | 94 +++++++++
 tb/tb_seq_detector_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with Moore match flag.
// Next-state table is built from PATTERN at elaboration (KMP style).
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8,
    localparam int                SW      = $clog2(PAT_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w,
    input  logic             en,
    input  logic             clear,
    output logic [SW-1:0]    q,
    output logic             z_s,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam logic [SW-1:0]    FULL    = SW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PEN = CNT_MAX - 1'b1;
    localparam int               TBL_N   = 2 ** (SW + 1);

    // Longest pattern prefix that is a suffix of (accepted prefix + b).
    // From the full state, non-overlap mode restarts from the empty prefix.
    function automatic logic [SW-1:0] next_state(int k, logic b);
        logic [16:0] s;
        int          base;
        int          n;
        int          best;
        logic        ok;
        s    = '0;
        base = (k == PAT_LEN && OVERLAP == 0) ? 0 : k;
        for (int i = 0; i < base; i++)
            s[i] = PATTERN[PAT_LEN-1-i];
        s[base] = b;
        n       = base + 1;
        best    = 0;
        for (int l = 1; l <= n; l++) begin
            if (l <= PAT_LEN) begin
                ok = 1'b1;
                for (int j = 0; j < l; j++)
                    if (s[n-l+j] != PATTERN[PAT_LEN-1-j])
                        ok = 1'b0;
                if (ok)
                    best = l;
            end
        end
        return best[SW-1:0];
    endfunction

    // Table indexed by {state, bit}; unreachable states map to S0.
    logic [SW-1:0] nxt_tbl [TBL_N];

    for (genvar i = 0; i < TBL_N; i++) begin : g_tbl
        if ((i / 2) <= PAT_LEN) begin : g_live
            localparam logic [SW-1:0] NXT = next_state(i / 2, (i % 2) == 1);
            assign nxt_tbl[i] = NXT;
        end else begin : g_dead
            assign nxt_tbl[i] = '0;
        end
    end

    logic [SW-1:0] nxt;
    logic          hit;

    assign nxt = nxt_tbl[{q, w}];
    assign hit = (nxt == FULL);

    // State, Moore flag and saturating counter; clear beats enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            z_s       <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (clear) begin
            q         <= '0;
            z_s       <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (en) begin
            q   <= nxt;
            z_s <= hit;
            if (hit && !cnt_sat) begin
                match_cnt <= match_cnt + 1'b1;
                cnt_sat   <= (match_cnt == CNT_PEN);
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: overlap, non-overlap and saturating variants
// driven from one shared stimulus stream.
module tb_seq_detector_param;

    logic       clk;
    logic       rst_n;
    logic       w;
    logic       en;
    logic       clear;

    logic [2:0] q_a;
    logic       z_a;
    logic [7:0] cnt_a;
    logic       sat_a;

    logic [2:0] q_b;
    logic       z_b;
    logic [7:0] cnt_b;
    logic       sat_b;

    logic [1:0] q_c;
    logic       z_c;
    logic [1:0] cnt_c;
    logic       sat_c;

    int n_tests;
    int n_fail;

    typedef struct {
        logic w;
        logic en;
        logic clr;
        int   qa;
        int   za;
        int   ca;
        int   qb;
        int   zb;
        int   cb;
    } vec_t;

    vec_t tv[$];

    seq_detector_param #(
        .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .w(w), .en(en), .clear(clear),
        .q(q_a), .z_s(z_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    seq_detector_param #(
        .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .w(w), .en(en), .clear(clear),
        .q(q_b), .z_s(z_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    seq_detector_param #(
        .PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .w(w), .en(en), .clear(clear),
        .q(q_c), .z_s(z_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int wi, int ei, int ci,
                                int qa, int za, int ca,
                                int qb, int zb, int cb);
        vec_t v;
        v.w   = (wi != 0);
        v.en  = (ei != 0);
        v.clr = (ci != 0);
        v.qa  = qa;
        v.za  = za;
        v.ca  = ca;
        v.qb  = qb;
        v.zb  = zb;
        v.cb  = cb;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, settle 1ns past it.
    task automatic step(input logic wi, input logic ei, input logic ci);
        w     = wi;
        en    = ei;
        clear = ci;
        @(posedge clk);
        #1;
    endtask

    int sat_cnt_exp [6];
    int sat_flg_exp [6];
    int sat_z_exp   [6];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        w       = 1'b0;
        en      = 1'b0;
        clear   = 1'b0;

        // w en clr | qa za ca | qb zb cb
        tv.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 1, 0, 2, 0, 0, 2, 0, 0));
        tv.push_back(mk(1, 1, 0, 3, 0, 0, 3, 0, 0));
        tv.push_back(mk(1, 1, 0, 4, 1, 1, 4, 1, 1));
        tv.push_back(mk(0, 1, 0, 2, 0, 1, 0, 0, 1));
        tv.push_back(mk(1, 1, 0, 3, 0, 1, 1, 0, 1));
        tv.push_back(mk(1, 1, 0, 4, 1, 2, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 4, 1, 2, 1, 0, 1));
        tv.push_back(mk(1, 0, 0, 4, 1, 2, 1, 0, 1));
        tv.push_back(mk(0, 1, 0, 2, 0, 2, 2, 0, 1));
        tv.push_back(mk(1, 1, 0, 3, 0, 2, 3, 0, 1));
        tv.push_back(mk(0, 0, 0, 3, 0, 2, 3, 0, 1));
        tv.push_back(mk(1, 0, 0, 3, 0, 2, 3, 0, 1));
        tv.push_back(mk(0, 0, 0, 3, 0, 2, 3, 0, 1));
        tv.push_back(mk(1, 1, 0, 4, 1, 3, 4, 1, 2));
        tv.push_back(mk(0, 0, 0, 4, 1, 3, 4, 1, 2));
        tv.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 1, 0, 2, 0, 0, 2, 0, 0));
        tv.push_back(mk(1, 1, 0, 3, 0, 0, 3, 0, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 1, 0, 2, 0, 0, 2, 0, 0));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0));

        sat_cnt_exp = '{0, 1, 2, 3, 3, 3};
        sat_flg_exp = '{0, 0, 0, 1, 1, 1};
        sat_z_exp   = '{0, 1, 1, 1, 1, 1};

        // Reset state with no clock edge yet
        #2;
        chk("rst_q",   int'(q_a),   0);
        chk("rst_z",   int'(z_a),   0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_sat", int'(sat_a), 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: overlap vs non-overlap, hold, clear
        foreach (tv[i]) begin
            step(tv[i].w, tv[i].en, tv[i].clr);
            chk($sformatf("v%0d_qa", i), int'(q_a),   tv[i].qa);
            chk($sformatf("v%0d_za", i), int'(z_a),   tv[i].za);
            chk($sformatf("v%0d_ca", i), int'(cnt_a), tv[i].ca);
            chk($sformatf("v%0d_qb", i), int'(q_b),   tv[i].qb);
            chk($sformatf("v%0d_zb", i), int'(z_b),   tv[i].zb);
            chk($sformatf("v%0d_cb", i), int'(cnt_b), tv[i].cb);
        end

        // Saturation on the 2-bit counter, all-ones pattern
        rst_n = 1'b0;
        #2;
        chk("c_rst_cnt", int'(cnt_c), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("sat%0d_cnt", i), int'(cnt_c), sat_cnt_exp[i]);
            chk($sformatf("sat%0d_flg", i), int'(sat_c), sat_flg_exp[i]);
            chk($sformatf("sat%0d_z", i),   int'(z_c),   sat_z_exp[i]);
        end
        chk("sat_q_a", int'(q_a), 1);

        // Asynchronous reset mid-stream, between edges
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_q", int'(q_a), 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q",     int'(q_a),   0);
        chk("arst_z",     int'(z_a),   0);
        chk("arst_cnt",   int'(cnt_a), 0);
        chk("arst_sat_c", int'(sat_c), 0);
        chk("arst_cnt_c", int'(cnt_c), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("post_z3", int'(z_a), 0);
        step(1'b1, 1'b1, 1'b0);
        chk("post_z",   int'(z_a),   1);
        chk("post_cnt", int'(cnt_a), 1);
        chk("post_q",   int'(q_a),   4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
